// File: rtl/cmos_rgb565_capture_if.sv
// Signal bundle between the DVP camera pins, the RGB565 capture block and the
// downstream frame-buffer FIFO controller.
interface cmos_rgb565_capture_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        wr_load;
    logic        datain_valid;
    logic [15:0] datain;
    logic        frame_valid;
    logic        line_err;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output wr_load, datain_valid, datain, frame_valid, line_err
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  wr_load, datain_valid, datain, frame_valid, line_err
    );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// DVP byte stream to RGB565 pixel converter: discards settling frames and pads
// every line to a multiple of 16 pixels for whole 256-bit write words.
module cmos_rgb565_capture #(
    parameter int unsigned WAIT_FRAMES = 10,
    parameter logic [15:0] PAD_PIXEL   = 16'h0000
) (
    input  logic                         wr_clk,
    input  logic                         rst_n,
    cmos_rgb565_capture_if.master        bus
);

    localparam logic [3:0] WAIT_CNT = WAIT_FRAMES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        vsync_d0_r;
    logic        vsync_d1_r;
    logic        href_d0_r;
    logic        href_d1_r;
    logic [7:0]  data_d0_r;

    logic [3:0]  settle_cnt_r;
    logic        frame_en_r;
    logic        byte_flag_r;
    logic [7:0]  hi_byte_r;
    logic [3:0]  pix_cnt_r;

    logic        wr_load_r;
    logic        datain_valid_r;
    logic [15:0] datain_r;
    logic        frame_valid_r;
    logic        line_err_r;

    logic        vs_rise_s;
    logic        href_rise_s;
    logic        href_fall_s;
    logic        merge_s;
    logic        pad_s;
    logic        abort_s;

    assign vs_rise_s   = vsync_d0_r & ~vsync_d1_r;
    assign href_rise_s = href_d0_r & ~href_d1_r;
    assign href_fall_s = ~href_d0_r & href_d1_r;
    // A vsync edge wins over any half-assembled pixel.
    assign merge_s     = href_d0_r & byte_flag_r & ~vs_rise_s;

    assign bus.wr_load      = wr_load_r;
    assign bus.datain_valid = datain_valid_r;
    assign bus.datain       = datain_r;
    assign bus.frame_valid  = frame_valid_r;
    assign bus.line_err     = line_err_r;

    // Line state register.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Line sequencing: active line, then pad up to the next 16-pixel boundary.
    always_comb begin
        state_nxt_s = state_r;
        pad_s       = 1'b0;
        abort_s     = 1'b0;
        if (vs_rise_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (href_rise_s) begin
                        state_nxt_s = ST_LINE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LINE: begin
                    if (href_fall_s) begin
                        if (pix_cnt_r == 4'd0) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_PAD;
                        end
                    end else begin
                        state_nxt_s = ST_LINE;
                    end
                end
                ST_PAD: begin
                    if (href_rise_s) begin
                        abort_s     = 1'b1;
                        state_nxt_s = ST_LINE;
                    end else begin
                        pad_s = 1'b1;
                        if (pix_cnt_r == 4'd15) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_PAD;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Input registration, frame settling and frame-start pulse.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d0_r    <= 1'b0;
            vsync_d1_r    <= 1'b0;
            href_d0_r     <= 1'b0;
            href_d1_r     <= 1'b0;
            data_d0_r     <= 8'h00;
            settle_cnt_r  <= 4'd0;
            frame_valid_r <= 1'b0;
            frame_en_r    <= 1'b0;
            wr_load_r     <= 1'b0;
        end else begin
            vsync_d0_r    <= bus.cam_vsync;
            vsync_d1_r    <= vsync_d0_r;
            href_d0_r     <= bus.cam_href;
            href_d1_r     <= href_d0_r;
            data_d0_r     <= bus.cam_data;
            wr_load_r     <= vs_rise_s;
            frame_valid_r <= (settle_cnt_r == WAIT_CNT);
            if (vs_rise_s) begin
                // A frame is emitted only when settling was complete at its start.
                frame_en_r <= frame_valid_r;
                if (settle_cnt_r < WAIT_CNT) begin
                    settle_cnt_r <= settle_cnt_r + 4'd1;
                end else begin
                    settle_cnt_r <= settle_cnt_r;
                end
            end else begin
                frame_en_r   <= frame_en_r;
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    // Byte pairing, pixel counting and pixel output.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_flag_r    <= 1'b0;
            hi_byte_r      <= 8'h00;
            pix_cnt_r      <= 4'd0;
            datain_r       <= 16'h0000;
            datain_valid_r <= 1'b0;
            line_err_r     <= 1'b0;
        end else begin
            datain_valid_r <= 1'b0;
            line_err_r     <= line_err_r | abort_s;

            if (vs_rise_s || !href_d0_r) begin
                byte_flag_r <= 1'b0;
            end else begin
                byte_flag_r <= ~byte_flag_r;
            end

            if (href_d0_r && !byte_flag_r) begin
                hi_byte_r <= data_d0_r;
            end else begin
                hi_byte_r <= hi_byte_r;
            end

            if (vs_rise_s || abort_s) begin
                pix_cnt_r <= 4'd0;
            end else if (merge_s || pad_s) begin
                pix_cnt_r <= pix_cnt_r + 4'd1;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end

            // Suppressed frames still count pixels so padding stays aligned.
            if (merge_s) begin
                datain_r       <= {hi_byte_r, data_d0_r};
                datain_valid_r <= frame_en_r;
            end else if (pad_s) begin
                datain_r       <= PAD_PIXEL;
                datain_valid_r <= frame_en_r;
            end else begin
                datain_r <= datain_r;
            end
        end
    end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Randomized bench for cmos_rgb565_capture against a frame/line level model.
module tb_cmos_rgb565_capture;
    localparam int          WAIT_FRAMES = 10;
    localparam logic [15:0] PAD_PIXEL   = 16'hF00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    cmos_rgb565_capture_if bus ();

    cmos_rgb565_capture #(
        .WAIT_FRAMES (WAIT_FRAMES),
        .PAD_PIXEL   (PAD_PIXEL)
    ) dut (
        .wr_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream and model state.
    logic [15:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] exp_q[$];
    int          exp_cyc[$];
    logic [7:0]  tx_bytes[$];
    int          wl_cnt = 0;
    int          wl_long = 0;
    logic        wl_prev = 1'b0;
    int          frames_seen = 0;
    bit          cur_en = 1'b0;
    bit          exp_err = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.datain_valid === 1'b1) begin
            got_q.push_back(bus.datain);
            got_cyc.push_back(cyc);
        end
        if (bus.wr_load === 1'b1) begin
            wl_cnt++;
            if (wl_prev) wl_long++;
        end
        wl_prev = bus.wr_load;
    end

    task automatic clear_streams();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        exp_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cam_href  = 1'b0;
            bus.cam_vsync = 1'b0;
            bus.cam_data  = 8'($urandom);
        end
    endtask

    task automatic start_frame();
        cur_en = (frames_seen >= WAIT_FRAMES);
        frames_seen++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.cam_vsync = 1'b1;
            bus.cam_href  = 1'b0;
        end
        idle(4);
    endtask

    task automatic fill_rand(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    // Sends one line and records what the design must emit for it.
    task automatic send_line(input int nbytes, input int gap);
        int np;
        int need;
        int pads;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = tx_bytes[i];
            if ((i % 2 == 1) && cur_en) begin
                exp_q.push_back({tx_bytes[i-1], tx_bytes[i]});
                exp_cyc.push_back(cyc + 2);
            end
        end
        np   = nbytes / 2;
        need = (16 - (np % 16)) % 16;
        if (need > 0 && gap - 1 < need) begin
            pads    = gap - 1;
            exp_err = 1'b1;
        end else begin
            pads = need;
        end
        if (cur_en) begin
            for (int i = 0; i < pads; i++) begin
                exp_q.push_back(PAD_PIXEL);
                exp_cyc.push_back(-1);
            end
        end
        tx_bytes.delete();
        idle(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.wr_load !== 1'b0) begin n_err++; $display("FAIL reset_wr_load got %b want 0", bus.wr_load); end
        n_cmp++; if (bus.datain_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.datain_valid); end
        n_cmp++; if (bus.datain !== 16'h0000) begin n_err++; $display("FAIL reset_datain got %h want 0000", bus.datain); end
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_frame_valid got %b want 0", bus.frame_valid); end
        n_cmp++; if (bus.line_err !== 1'b0) begin n_err++; $display("FAIL reset_line_err got %b want 0", bus.line_err); end
        rst_n = 1'b1;
        frames_seen = 0;
        exp_err = 1'b0;
        idle(5);
    endtask

    task automatic test_frames();
        clear_streams();
        wl_cnt = 0;
        wl_long = 0;
        for (int f = 0; f < 12; f++) begin
            start_frame();
            fill_rand(32); send_line(32, 20);
            fill_rand(32); send_line(32, 20);
        end
        n_cmp++; if (wl_cnt != 12) begin n_err++; $display("FAIL frames_wr_load_count got %0d want 12", wl_cnt); end
        n_cmp++; if (wl_long != 0) begin n_err++; $display("FAIL frames_wr_load_width got %0d long pulses want 0", wl_long); end
        n_cmp++; if (got_q.size() != 64) begin n_err++; $display("FAIL frames_pixel_count got %0d want 64", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frames_pixel[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL frames_frame_valid got %b want 1", bus.frame_valid); end
        n_cmp++; if (bus.line_err !== exp_err) begin n_err++; $display("FAIL frames_line_err got %b want %b", bus.line_err, exp_err); end
    endtask

    task automatic test_bytes();
        clear_streams();
        start_frame();
        tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_line(4, 20);
        n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL bytes_count got %0d want 16", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_cmp++; if (got_q[0] !== 16'hA1B2) begin n_err++; $display("FAIL bytes_pix0 got %h want a1b2", got_q[0]); end
            n_cmp++; if (got_q[1] !== 16'hC3D4) begin n_err++; $display("FAIL bytes_pix1 got %h want c3d4", got_q[1]); end
            n_cmp++; if (got_cyc[0] != exp_cyc[0]) begin n_err++; $display("FAIL bytes_latency0 got cycle %0d want %0d", got_cyc[0], exp_cyc[0]); end
            n_cmp++; if (got_cyc[1] != exp_cyc[1]) begin n_err++; $display("FAIL bytes_latency1 got cycle %0d want %0d", got_cyc[1], exp_cyc[1]); end
        end
        for (int i = 2; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bytes_pad[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_pad();
        clear_streams();
        start_frame();
        fill_rand(40);
        send_line(40, 20);
        n_cmp++; if (got_q.size() != 32) begin n_err++; $display("FAIL pad_count got %0d want 32", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pad_pixel[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 21; i < 32 && i < got_cyc.size(); i++) begin
            n_cmp++;
            if (got_cyc[i] != got_cyc[i-1] + 1) begin n_err++; $display("FAIL pad_consecutive[%0d] got gap %0d want 1", i, got_cyc[i] - got_cyc[i-1]); end
        end
        n_cmp++; if (bus.line_err !== 1'b0) begin n_err++; $display("FAIL pad_line_err got %b want 0", bus.line_err); end
    endtask

    task automatic test_abort();
        clear_streams();
        start_frame();
        fill_rand(10);
        send_line(10, 5);
        fill_rand(34);
        send_line(34, 20);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_pixel[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (bus.line_err !== 1'b1) begin n_err++; $display("FAIL abort_line_err got %b want 1", bus.line_err); end
    endtask

    task automatic test_odd();
        clear_streams();
        start_frame();
        fill_rand(7);
        send_line(7, 20);
        n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL odd_count got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL odd_pixel[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midline();
        clear_streams();
        start_frame();
        fill_rand(9);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = tx_bytes[i];
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.datain_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got %b want 0", bus.datain_valid); end
        n_cmp++; if (bus.datain !== 16'h0000) begin n_err++; $display("FAIL midreset_datain got %h want 0000", bus.datain); end
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL midreset_frame_valid got %b want 0", bus.frame_valid); end
        n_cmp++; if (bus.line_err !== 1'b0) begin n_err++; $display("FAIL midreset_line_err got %b want 0", bus.line_err); end
        idle(3);
        rst_n = 1'b1;
        frames_seen = 0;
        exp_err = 1'b0;
        clear_streams();
        idle(3);
        for (int f = 0; f <= WAIT_FRAMES; f++) begin
            start_frame();
            fill_rand(32);
            send_line(32, 20);
        end
        n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL midreset_count got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midreset_pixel[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_bytes();
        test_pad();
        test_abort();
        test_odd();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
